// File: rtl/ysyx_lsu_l1d_pkg.sv
// ysyx_lsu_l1d_pkg: shared op encodings, FSM states, cacheable window and byte-lane helpers
package ysyx_lsu_l1d_pkg;
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [31:0] L1D_CACHE_LO = 32'h8000_0000;
    localparam logic [31:0] L1D_CACHE_HI = 32'h8800_0000;
    typedef enum logic [2:0] {S_IDLE, S_ERR, S_HIT, S_RD, S_WR, S_RESP} state_e;
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        return sz == 2'b00 ? 4'b0001 : sz == 2'b01 ? 4'b0011 : 4'b1111;
    endfunction
    function automatic logic op_legal(input logic [2:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        return (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
    endfunction
    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] w, input logic [1:0] off);
        logic [3:0] m;
        m = size_mask(sz);
        return (w & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}}) << {off, 3'b000};
    endfunction
    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] word, input logic [1:0] off);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        return op == OP_LB ? {{24{s[7]}}, s[7:0]} : op == OP_LH ? {{16{s[15]}}, s[15:0]} :
               op == OP_LBU ? {24'h0, s[7:0]} : op == OP_LHU ? {16'h0, s[15:0]} : s;
    endfunction
endpackage

// File: rtl/ysyx_lsu_l1d_array.sv
// ysyx_l1d_array: direct-mapped valid/tag/data store with comb read, fill, byte merge and flush-all
module ysyx_l1d_array #(
    parameter int SET_BITS = 4,
    parameter int TAG_W    = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_all,
    input  logic [SET_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [31:0]         rd_data,
    input  logic [SET_BITS-1:0] wr_idx,
    input  logic                fill_en,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [31:0]         fill_data,
    input  logic                merge_en,
    input  logic [3:0]          merge_strb,
    input  logic [31:0]         merge_data
);
    localparam int SETS = 1 << SET_BITS;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [SETS];
    logic [TAG_W-1:0] tag_d [SETS];
    logic [31:0]      data_q [SETS];
    logic [31:0]      data_d [SETS];
    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];
    // next line state: fill replaces the line, merge patches strobed bytes, flush clears every valid bit last
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = fill_tag;
            data_d[wr_idx]  = fill_data;
        end
        if (merge_en)
            for (int b = 0; b < 4; b++)
                if (merge_strb[b]) data_d[wr_idx][8*b +: 8] = merge_data[8*b +: 8];
        if (flush_all) valid_d = '0;
    end
    // only valid bits need reset; tag/data are qualified by them
    always_ff @(posedge clk or posedge rst)
        if (rst) valid_q <= '0;
        else valid_q <= valid_d;
    // tag and data storage
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: rtl/ysyx_lsu_l1d.sv
// ysyx_lsu_l1d: load/store unit with direct-mapped write-through no-allocate L1 data cache
module ysyx_lsu_l1d
    import ysyx_lsu_l1d_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                SET_BITS = 4,
    parameter logic [ADDR_W-1:0] CACHE_LO = L1D_CACHE_LO,
    parameter logic [ADDR_W-1:0] CACHE_HI = L1D_CACHE_HI
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] bus_araddr,
    output logic              bus_arvalid,
    output logic [3:0]        bus_rstrb,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid,
    output logic [ADDR_W-1:0] bus_awaddr,
    output logic              bus_awvalid,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    output logic              bus_wvalid,
    input  logic              bus_wready
);
    localparam int TAG_W = ADDR_W - SET_BITS - 2;
    state_e              state_q, state_d;
    logic                wen_q, wen_d, flush_pend_q, flush_pend_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic                idle, accept, do_flush, req_err, hit, fill_en, merge_en, arr_valid;
    logic [SET_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]    lk_tag, arr_tag;
    logic [31:0]         arr_data, lane_wdata;
    logic [3:0]          lane_strb;

    function automatic logic cacheable(input logic [ADDR_W-1:0] a);
        return a >= CACHE_LO && a < CACHE_HI;
    endfunction

    ysyx_l1d_array #(.SET_BITS(SET_BITS), .TAG_W(TAG_W)) u_array (
        .clk(clk), .rst(rst), .flush_all(do_flush),
        .rd_idx(lk_idx), .rd_valid(arr_valid), .rd_tag(arr_tag), .rd_data(arr_data),
        .wr_idx(addr_q[SET_BITS+1:2]),
        .fill_en(fill_en), .fill_tag(addr_q[ADDR_W-1:SET_BITS+2]), .fill_data(bus_rdata),
        .merge_en(merge_en), .merge_strb(lane_strb), .merge_data(lane_wdata)
    );

    // lookup from the live request in IDLE and the latched one otherwise; flushes only land in IDLE
    always_comb begin
        idle         = state_q == S_IDLE;
        accept       = idle & req_valid;
        do_flush     = idle & (flush | flush_pend_q);
        lk_idx       = idle ? req_addr[SET_BITS+1:2] : addr_q[SET_BITS+1:2];
        lk_tag       = idle ? req_addr[ADDR_W-1:SET_BITS+2] : addr_q[ADDR_W-1:SET_BITS+2];
        hit          = arr_valid & (arr_tag == lk_tag);
        req_err      = !op_legal(req_op) | misaligned(req_op[1:0], req_addr[1:0]);
        wen_d        = accept ? req_wen : wen_q;
        op_d         = accept ? req_op : op_q;
        addr_d       = accept ? req_addr : addr_q;
        wdata_d      = accept ? req_wdata : wdata_q;
        rdata_d      = state_q == S_RD && bus_rvalid ? bus_rdata : rdata_q;
        flush_pend_d = !idle & (flush_pend_q | flush);
        fill_en      = state_q == S_RD && bus_rvalid && cacheable(addr_q);
        merge_en     = state_q == S_WR && bus_wready && hit && cacheable(addr_q);
        lane_strb    = size_mask(op_q[1:0]) << addr_q[1:0];
        lane_wdata   = lane_data(op_q[1:0], wdata_q, addr_q[1:0]);
    end

    // sequencing FSM next state; a flush taken with the accept forces the lookup to miss
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = !req_valid ? S_IDLE : req_err ? S_ERR : req_wen ? S_WR :
                              (hit && !do_flush && cacheable(req_addr)) ? S_HIT : S_RD;
            S_RD:   state_d = bus_rvalid ? S_RESP : S_RD;
            S_WR:   state_d = bus_wready ? S_RESP : S_WR;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: bus driven only from latched request fields
    always_comb begin
        req_ready   = idle;
        resp_valid  = state_q == S_ERR || state_q == S_HIT || state_q == S_RESP;
        resp_err    = state_q == S_ERR;
        resp_rdata  = state_q == S_HIT ? load_ext(op_q, arr_data, addr_q[1:0]) :
                      (state_q == S_RESP && !wen_q) ? load_ext(op_q, rdata_q, addr_q[1:0]) : '0;
        bus_arvalid = state_q == S_RD;
        bus_araddr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus_rstrb   = state_q == S_RD ? lane_strb : 4'b0000;
        bus_awvalid = state_q == S_WR;
        bus_wvalid  = state_q == S_WR;
        bus_awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus_wstrb   = state_q == S_WR ? lane_strb : 4'b0000;
        bus_wdata   = state_q == S_WR ? lane_wdata : '0;
    end

    // state and request registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= S_IDLE;
            wen_q        <= 1'b0;
            op_q         <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            flush_pend_q <= flush_pend_d;
        end
endmodule
